// File: rtl/serial_pattern_gen_if.sv
// Job-load handshake and serial output bundle for serial_pattern_gen.
// The master drives the job request and abort, and the generator (slave)
// drives the serial line and status flags.
interface serial_pattern_gen_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rep_in;
    logic             abort;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pat_in, rep_in, abort,
        input  load_ready, x_out, x_valid, busy, done
    );

    modport slave (
        input  load_valid, pat_in, rep_in, abort,
        output load_ready, x_out, x_valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter.
// It sends a PAT_W-bit pattern MSB first and repeats it (rep_in + 1) times,
// with GAP_CYC idle cycles between repetitions. After the last bit it emits
// a one-cycle done pulse. All outputs are registers, and each one is loaded
// with the value that belongs to the state being entered.
module serial_pattern_gen #(
    parameter int PAT_W   = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_pattern_gen_if.slave  bus
);

    localparam int BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LOAD);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_reg;
    logic [CNT_W-1:0] rep_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;

    logic load_ready_r;
    logic x_out_r;
    logic x_valid_r;
    logic busy_r;
    logic done_r;

    assign bus.load_ready = load_ready_r;
    assign bus.x_out      = x_out_r;
    assign bus.x_valid    = x_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    // Job sequencer: the state, the job registers and the registered outputs
    // all update together, so every output lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pat_reg      <= '0;
            rep_cnt      <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            load_ready_r <= 1'b1;
            x_out_r      <= 1'b0;
            x_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid && !bus.abort) begin
                        state        <= SHIFT;
                        pat_reg      <= bus.pat_in;
                        rep_cnt      <= bus.rep_in;
                        bit_idx      <= LAST_IDX;
                        load_ready_r <= 1'b0;
                        x_out_r      <= bus.pat_in[PAT_W-1];
                        x_valid_r    <= 1'b1;
                        busy_r       <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state        <= IDLE;
                        rep_cnt      <= '0;
                        load_ready_r <= 1'b1;
                        x_out_r      <= 1'b0;
                        x_valid_r    <= 1'b0;
                        busy_r       <= 1'b0;
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - BIT_W'(1);
                        x_out_r <= pat_reg[bit_idx - BIT_W'(1)];
                    end else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - CNT_W'(1);
                        bit_idx <= LAST_IDX;
                        if (GAP_CYC == 0) begin
                            x_out_r <= pat_reg[PAT_W-1];
                        end else begin
                            state     <= GAP;
                            gap_cnt   <= GAP_INIT;
                            x_out_r   <= 1'b0;
                            x_valid_r <= 1'b0;
                        end
                    end else begin
                        state     <= DONE;
                        done_r    <= 1'b1;
                        x_out_r   <= 1'b0;
                        x_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        state        <= IDLE;
                        rep_cnt      <= '0;
                        load_ready_r <= 1'b1;
                        x_out_r      <= 1'b0;
                        x_valid_r    <= 1'b0;
                        busy_r       <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state     <= SHIFT;
                        x_out_r   <= pat_reg[PAT_W-1];
                        x_valid_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    done_r       <= 1'b0;
                    load_ready_r <= 1'b1;
                end

                default: begin
                    state        <= IDLE;
                    load_ready_r <= 1'b1;
                    x_out_r      <= 1'b0;
                    x_valid_r    <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Testbench for serial_pattern_gen. It runs two instances side by side, one
// with a one-cycle gap between repetitions and one without, and feeds both
// the same job requests. Each instance is checked against a queue-based
// model of the expected output stream.
module tb_serial_pattern_gen;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;

    // Output bundle order: load_ready, x_valid, x_out, busy, done.
    typedef struct packed {
        logic load_ready;
        logic x_valid;
        logic x_out;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        logic             lv;
        logic [PAT_W-1:0] pat;
        logic [CNT_W-1:0] rep;
        logic             ab;
        out_t             exp;
    } vec_t;

    localparam out_t IDLE_O = 5'b10000;
    localparam out_t GAP_O  = 5'b00010;
    localparam out_t DONE_O = 5'b00001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lv;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rep;
    logic             abrt;

    int vec_count   = 0;
    int miscompares = 0;

    // Model state: each instance has a queue of expected future cycles and
    // the output expected in the current cycle.
    out_t exp_q0[$];
    out_t exp_q1[$];
    out_t cur0;
    out_t cur1;

    // Observation statistics, including a software 1-1-0 sequence detector
    // that looks only at the valid bits.
    int busy_a, busy_b, done_a, done_b, valid_a, valid_b, hits_a, hits_b;
    logic [2:0] hist_a, hist_b;

    always #5 clk = ~clk;

    serial_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_a ();
    serial_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.load_valid = lv;
    assign bus_a.pat_in     = pat;
    assign bus_a.rep_in     = rep;
    assign bus_a.abort      = abrt;
    assign bus_b.load_valid = lv;
    assign bus_b.pat_in     = pat;
    assign bus_b.rep_in     = rep;
    assign bus_b.abort      = abrt;

    serial_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(1)) dut_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    serial_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(0)) dut_nogap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    function automatic out_t sampleA();
        return {bus_a.load_ready, bus_a.x_valid, bus_a.x_out, bus_a.busy, bus_a.done};
    endfunction

    function automatic out_t sampleB();
        return {bus_b.load_ready, bus_b.x_valid, bus_b.x_out, bus_b.busy, bus_b.done};
    endfunction

    // Build the whole expected cycle stream of a job: the pattern bits
    // (rep + 1) times, gap cycles between repetitions, then the done cycle.
    function automatic void loadJob(int m, int gap, logic [PAT_W-1:0] p, logic [CNT_W-1:0] r);
        out_t job[$];
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                job.push_back(out_t'({1'b0, 1'b1, p[b], 1'b1, 1'b0}));
            if (k < int'(r))
                for (int g = 0; g < gap; g++) job.push_back(GAP_O);
        end
        job.push_back(DONE_O);
        if (m == 0) exp_q0 = job;
        else        exp_q1 = job;
    endfunction

    // Expected output after the coming edge, given the current inputs.
    function automatic out_t nextOut(int m);
        out_t cur = (m == 0) ? cur0 : cur1;
        if (cur.busy && abrt) begin
            if (m == 0) exp_q0.delete();
            else        exp_q1.delete();
            return IDLE_O;
        end
        if (cur.load_ready && lv && !abrt) loadJob(m, (m == 0) ? 1 : 0, pat, rep);
        if (m == 0) begin
            if (exp_q0.size() > 0) return exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) return exp_q1.pop_front();
        end
        return IDLE_O;
    endfunction

    task automatic modelReset();
        exp_q0.delete();
        exp_q1.delete();
        cur0 = IDLE_O;
        cur1 = IDLE_O;
    endtask

    task automatic resetStats();
        busy_a = 0; busy_b = 0; done_a = 0; done_b = 0;
        valid_a = 0; valid_b = 0; hits_a = 0; hits_b = 0;
        hist_a = '0; hist_b = '0;
    endtask

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b expected %b (ready,valid,out,busy,done)",
                     name, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        vec_count++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: advance the model, take the edge, then compare on the falling edge.
    task automatic tick();
        out_t n0, n1, a, b;
        n0 = nextOut(0);
        n1 = nextOut(1);
        @(posedge clk);
        cur0 = n0;
        cur1 = n1;
        @(negedge clk);
        a = sampleA();
        b = sampleB();
        checkOutput("model_gap1", a, cur0);
        checkOutput("model_gap0", b, cur1);
        if (a.busy) busy_a++;
        if (b.busy) busy_b++;
        if (a.done) done_a++;
        if (b.done) done_b++;
        if (a.x_valid) begin
            valid_a++;
            hist_a = {hist_a[1:0], a.x_out};
            if (hist_a == 3'b110) hits_a++;
        end
        if (b.x_valid) begin
            valid_b++;
            hist_b = {hist_b[1:0], b.x_out};
            if (hist_b == 3'b110) hits_b++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [PAT_W-1:0] p,
                                 input logic [CNT_W-1:0] r, input logic a);
        lv   = v;
        pat  = p;
        rep  = r;
        abrt = a;
        tick();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    vec_t tbl[12];

    initial begin
        // Single send of 110 with ignored requests while busy and in DONE,
        // then abort blocking a load in IDLE, then a clean load of 011.
        tbl[0]  = '{1'b1, 3'b110, 4'd0, 1'b0, out_t'(5'b01110)};
        tbl[1]  = '{1'b1, 3'b001, 4'd7, 1'b0, out_t'(5'b01110)};
        tbl[2]  = '{1'b1, 3'b001, 4'd7, 1'b0, out_t'(5'b01010)};
        tbl[3]  = '{1'b1, 3'b001, 4'd7, 1'b0, DONE_O};
        tbl[4]  = '{1'b1, 3'b001, 4'd7, 1'b0, IDLE_O};
        tbl[5]  = '{1'b1, 3'b011, 4'd0, 1'b1, IDLE_O};
        tbl[6]  = '{1'b1, 3'b011, 4'd0, 1'b1, IDLE_O};
        tbl[7]  = '{1'b1, 3'b011, 4'd0, 1'b0, out_t'(5'b01010)};
        tbl[8]  = '{1'b0, 3'b000, 4'd0, 1'b0, out_t'(5'b01110)};
        tbl[9]  = '{1'b0, 3'b000, 4'd0, 1'b0, out_t'(5'b01110)};
        tbl[10] = '{1'b0, 3'b000, 4'd0, 1'b0, DONE_O};
        tbl[11] = '{1'b0, 3'b000, 4'd0, 1'b0, IDLE_O};

        rst_n = 1'b0;
        lv = 1'b0; pat = '0; rep = '0; abrt = 1'b0;
        modelReset();
        resetStats();
        #12;
        checkOutput("reset_gap1", sampleA(), IDLE_O);
        checkOutput("reset_gap0", sampleB(), IDLE_O);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].lv, tbl[i].pat, tbl[i].rep, tbl[i].ab);
            checkOutput($sformatf("table_%0d", i), sampleA(), tbl[i].exp);
        end

        $display("[TB] 101 x3 with gaps");
        resetStats();
        applyStimulus(1'b1, 3'b101, 4'd2, 1'b0);
        idleCycles(13);
        checkCount("busy_cycles_gap1", busy_a, 11);
        checkCount("busy_cycles_gap0", busy_b, 9);
        checkCount("done_pulses_gap1", done_a, 1);
        checkCount("done_pulses_gap0", done_b, 1);
        checkCount("valid_bits_gap1", valid_a, 9);

        $display("[TB] abort after second bit");
        resetStats();
        applyStimulus(1'b1, 3'b111, 4'd3, 1'b0);
        applyStimulus(1'b0, 3'b000, 4'd0, 1'b0);
        applyStimulus(1'b0, 3'b000, 4'd0, 1'b1);
        checkOutput("abort_to_idle", sampleA(), IDLE_O);
        idleCycles(4);
        checkCount("abort_no_done", done_a + done_b, 0);
        applyStimulus(1'b1, 3'b010, 4'd0, 1'b0);
        idleCycles(5);
        checkCount("after_abort_done", done_a, 1);

        $display("[TB] async reset mid-shift");
        applyStimulus(1'b1, 3'b110, 4'd5, 1'b0);
        idleCycles(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_gap1", sampleA(), IDLE_O);
        checkOutput("async_reset_gap0", sampleB(), IDLE_O);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resetStats();
        idleCycles(8);
        checkCount("no_done_after_reset", done_a + done_b, 0);

        $display("[TB] 110 x4 into sequence detector");
        resetStats();
        applyStimulus(1'b1, 3'b110, 4'd3, 1'b0);
        idleCycles(16);
        checkCount("detector_hits_gap0", hits_b, 4);
        checkCount("detector_hits_gap1", hits_a, 4);
        checkCount("valid_bits_gap0", valid_b, 12);

        $display("[TB] max repetition count");
        resetStats();
        applyStimulus(1'b1, 3'b110, 4'hF, 1'b0);
        idleCycles(70);
        checkCount("max_rep_bits_gap1", valid_a, 48);
        checkCount("max_rep_bits_gap0", valid_b, 48);
        checkCount("max_rep_busy_gap1", busy_a, 63);
        checkCount("max_rep_done", done_a, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), PAT_W'($urandom),
                          CNT_W'($urandom_range(0, 5)), ($urandom_range(0, 15) == 0));
        end
        idleCycles(30);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
